// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, debug and data_memory signals around the data-memory arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [BIT_WIDTH-1:0] cpu_addr;
  logic [BIT_WIDTH-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_stall;
  logic                 cpu_rvalid;
  logic [BIT_WIDTH-1:0] cpu_rdata;

  logic                 dbg_req;
  logic                 dbg_we;
  logic                 dbg_lock;
  logic [BIT_WIDTH-1:0] dbg_addr;
  logic [BIT_WIDTH-1:0] dbg_wdata;
  logic                 dbg_gnt;
  logic                 dbg_rvalid;
  logic [BIT_WIDTH-1:0] dbg_rdata;

  logic [BIT_WIDTH-1:0] mem_addr;
  logic                 mem_we;
  logic [BIT_WIDTH-1:0] mem_wdata;
  logic [BIT_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data_memory port between the CPU memory stage and a debug/loader port:
// CPU priority, starvation guard for debug, and a lock mode for debug bursts.
module dmem_arbiter #(
  parameter int BIT_WIDTH    = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  typedef enum logic {ARB = 1'b0, DBG_LOCK = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     starve_cnt_reg, starve_cnt_next;
  logic                 cpu_rvalid_reg, dbg_rvalid_reg;
  logic                 cpu_gnt_c, dbg_gnt_c;
  logic                 mem_we_c;
  logic [BIT_WIDTH-1:0] mem_addr_c, mem_wdata_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ARB;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ARB) begin
      if (dbg_gnt_c && bus.dbg_lock) state_next = DBG_LOCK;
    end else begin
      if ((dbg_gnt_c && !bus.dbg_lock) || !bus.dbg_req) state_next = ARB;
    end
  end

  // Grants are suppressed while reset is held so no write can slip into memory.
  always_comb begin
    cpu_gnt_c   = 1'b0;
    dbg_gnt_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (!reset) begin
      if (state_reg == ARB) begin
        if (bus.cpu_req && bus.dbg_req) begin
          if (starve_cnt_reg == LIMIT) dbg_gnt_c = 1'b1;
          else                         cpu_gnt_c = 1'b1;
        end else begin
          cpu_gnt_c = bus.cpu_req;
          dbg_gnt_c = bus.dbg_req;
        end
      end else begin
        dbg_gnt_c = bus.dbg_req;
      end
    end
    if (cpu_gnt_c) begin
      mem_we_c    = bus.cpu_we;
      mem_addr_c  = bus.cpu_addr;
      mem_wdata_c = bus.cpu_wdata;
    end else if (dbg_gnt_c) begin
      mem_we_c    = bus.dbg_we;
      mem_addr_c  = bus.dbg_addr;
      mem_wdata_c = bus.dbg_wdata;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!bus.dbg_req || dbg_gnt_c) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // Response flags line up with data_memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
      cpu_rvalid_reg <= 1'b0;
      dbg_rvalid_reg <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      cpu_rvalid_reg <= cpu_gnt_c && !bus.cpu_we;
      dbg_rvalid_reg <= dbg_gnt_c && !bus.dbg_we;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_c;
  assign bus.dbg_gnt    = dbg_gnt_c;
  assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt_c;
  assign bus.mem_we     = mem_we_c;
  assign bus.mem_addr   = mem_addr_c;
  assign bus.mem_wdata  = mem_wdata_c;
  // A reset landing on the response cycle drops that response.
  assign bus.cpu_rvalid = cpu_rvalid_reg && !reset;
  assign bus.dbg_rvalid = dbg_rvalid_reg && !reset;
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(cpu_gnt_c && dbg_gnt_c))
        else $error("dmem_arbiter: both ports granted");
      assert (!mem_we_c || cpu_gnt_c || dbg_gnt_c)
        else $error("dmem_arbiter: mem_we without grant");
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_memory and a read-response scoreboard.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc    = 0;
  int   total  = 0;
  int   passes = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  resp_t    cpu_q[$];
  resp_t    dbg_q[$];
  bit [31:0] mem_array [0:63];
  bit [31:0] shadow    [0:63];

  dmem_arbiter_if #(.BIT_WIDTH(32)) bus();

  dmem_arbiter #(.BIT_WIDTH(32), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: write at the edge, read data one cycle later
  always @(posedge clk) begin
    if (bus.mem_we) mem_array[bus.mem_addr[7:2]] <= bus.mem_wdata;
    bus.mem_rdata <= mem_array[bus.mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic step(input bit ecg, input bit edg);
    bit          cdue, ddue;
    logic [31:0] cexp, dexp;
    @(negedge clk);
    chk("cpu_gnt", {31'b0, bus.cpu_gnt}, {31'b0, ecg});
    chk("dbg_gnt", {31'b0, bus.dbg_gnt}, {31'b0, edg});
    chk("cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, bus.cpu_req && !ecg});
    if (ecg) begin
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, bus.cpu_we});
      chk("mem_addr", bus.mem_addr, bus.cpu_addr);
      chk("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
    end else if (edg) begin
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, bus.dbg_we});
      chk("mem_addr", bus.mem_addr, bus.dbg_addr);
      chk("mem_wdata", bus.mem_wdata, bus.dbg_wdata);
    end else begin
      chk("mem_we_idle", {31'b0, bus.mem_we}, 32'h0);
      chk("mem_addr_idle", bus.mem_addr, 32'h0);
      chk("mem_wdata_idle", bus.mem_wdata, 32'h0);
    end
    cdue = 1'b0; cexp = 32'h0;
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      cdue = !reset;
      cexp = reset ? 32'h0 : cpu_q[0].data;
      void'(cpu_q.pop_front());
    end
    ddue = 1'b0; dexp = 32'h0;
    if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
      ddue = !reset;
      dexp = reset ? 32'h0 : dbg_q[0].data;
      void'(dbg_q.pop_front());
    end
    chk("cpu_rvalid", {31'b0, bus.cpu_rvalid}, {31'b0, cdue});
    chk("cpu_rdata", bus.cpu_rdata, cexp);
    chk("dbg_rvalid", {31'b0, bus.dbg_rvalid}, {31'b0, ddue});
    chk("dbg_rdata", bus.dbg_rdata, dexp);
    $display("cyc=%0d rst=%0b cpu_gnt=%0b dbg_gnt=%0b mem_we=%0b mem_addr=%h cpu_rv=%0b dbg_rv=%0b",
             cyc, reset, bus.cpu_gnt, bus.dbg_gnt, bus.mem_we, bus.mem_addr,
             bus.cpu_rvalid, bus.dbg_rvalid);
    if (ecg) begin
      if (bus.cpu_we) shadow[bus.cpu_addr[7:2]] = bus.cpu_wdata;
      else cpu_q.push_back('{due: cyc + 1, data: shadow[bus.cpu_addr[7:2]]});
    end else if (edg) begin
      if (bus.dbg_we) shadow[bus.dbg_addr[7:2]] = bus.dbg_wdata;
      else dbg_q.push_back('{due: cyc + 1, data: shadow[bus.dbg_addr[7:2]]});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    // reset held with both ports requesting writes
    reset         = 1'b1;
    bus.cpu_req   = 1'b1; bus.cpu_we = 1'b1;
    bus.cpu_addr  = 32'h24; bus.cpu_wdata = 32'h1111_0000;
    bus.dbg_req   = 1'b1; bus.dbg_we = 1'b1; bus.dbg_lock = 1'b0;
    bus.dbg_addr  = 32'h20; bus.dbg_wdata = 32'h2222_0000;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;

    // continuous contention: four CPU grants, then debug wins by starvation
    for (int i = 0; i < 10; i++) begin
      step(i % 5 != 4, i % 5 == 4);
      if (i % 5 != 4) begin
        bus.cpu_addr  = bus.cpu_addr + 32'h4;
        bus.cpu_wdata = $urandom;
      end else begin
        bus.dbg_addr  = bus.dbg_addr + 32'h40;
        bus.dbg_wdata = $urandom;
      end
    end

    // debug lock burst of three writes while the CPU keeps reading
    bus.cpu_we   = 1'b0; bus.cpu_addr = 32'h24;
    bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'hA000_0001; bus.dbg_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      bus.cpu_addr = bus.cpu_addr + 32'h4;
    end
    for (int b = 0; b < 3; b++) begin
      step(1'b0, 1'b1);
      bus.dbg_addr  = bus.dbg_addr + 32'h4;
      bus.dbg_wdata = bus.dbg_wdata + 32'h1;
      bus.dbg_lock  = (b == 0);
    end
    bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0;
    step(1'b1, 1'b0);

    // CPU store then load of the same word
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEAD_BEEF;
    step(1'b1, 1'b0);
    bus.cpu_we = 1'b0;
    step(1'b1, 1'b0);
    bus.cpu_req = 1'b0;
    step(1'b0, 1'b0);

    // debug read granted by starvation, CPU read of 0x24 the cycle after
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h30;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      bus.cpu_addr = (i == 3) ? 32'h24 : bus.cpu_addr + 32'h4;
    end
    step(1'b0, 1'b1);
    bus.dbg_req = 1'b0;
    step(1'b1, 1'b0);
    bus.cpu_req = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // reset on the response cycle of a CPU read
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h24;
    step(1'b1, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0; bus.cpu_req = 1'b0;
    step(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
